// File: rtl/tl_phase_scheduler.sv
// Two-road traffic-light phase scheduler with pedestrian walk and flash mode.
// Optional road-2 demand skipping is enabled by defining TL_DEMAND_EN (adds VDET2).
module tl_phase_scheduler #(
   parameter int TW   = 4,
   parameter int G1_T = 10,
   parameter int G2_T = 6,
   parameter int Y_T  = 3,
   parameter int AR_T = 1,
   parameter int W_T  = 4
) (
   input  logic       CK,
   input  logic       CLR,
   input  logic       TICK,
   input  logic       TEST,
   input  logic       FM,
   input  logic       PREQ,
`ifdef TL_DEMAND_EN
   input  logic       VDET2,
`endif
   output logic       PACK,
   output logic       GRN1,
   output logic       YLW1,
   output logic       RED1,
   output logic       GRN2,
   output logic       YLW2,
   output logic       RED2,
   output logic       WALK,
   output logic [2:0] PHASE
);

   typedef enum logic [2:0] {
      S_G1 = 3'd0, S_Y1 = 3'd1, S_AR1 = 3'd2, S_G2 = 3'd3,
      S_Y2 = 3'd4, S_AR2 = 3'd5, S_PW = 3'd6, S_FLASH = 3'd7
   } state_t;

   localparam logic [TW-1:0] G1_L = TW'(G1_T - 1);
   localparam logic [TW-1:0] G2_L = TW'(G2_T - 1);
   localparam logic [TW-1:0] Y_L  = TW'(Y_T - 1);
   localparam logic [TW-1:0] AR_L = TW'(AR_T - 1);
   localparam logic [TW-1:0] W_L  = TW'(W_T - 1);

   // Lamp vector order: {GRN1, YLW1, RED1, GRN2, YLW2, RED2, WALK}
   localparam logic [6:0] LAMPS_RESET = 7'b0010010;

   state_t        state, state_nx;
   logic [TW-1:0] timer, timer_nx;
   logic          pending, pending_nx;
   logic          blink, blink_nx;
   logic          pack_nx;
   logic [6:0]    lamps, lamps_nx;
   logic          step;
`ifdef TL_DEMAND_EN
   logic          demand, demand_nx;
`endif

   function automatic logic [TW-1:0] load_of(input state_t s);
      case (s)
         S_G1:    load_of = G1_L;
         S_Y1:    load_of = Y_L;
         S_G2:    load_of = G2_L;
         S_Y2:    load_of = Y_L;
         S_PW:    load_of = W_L;
         S_FLASH: load_of = '0;
         default: load_of = AR_L;
      endcase
   endfunction

   function automatic logic [6:0] decode(input state_t s, input logic b);
      case (s)
         S_G1:    decode = 7'b1000010;
         S_Y1:    decode = 7'b0100010;
         S_G2:    decode = 7'b0011000;
         S_Y2:    decode = 7'b0010100;
         S_PW:    decode = 7'b0010011;
         S_FLASH: decode = {1'b0, b, 1'b0, 1'b0, 1'b0, b, 1'b0};
         default: decode = 7'b0010010;
      endcase
   endfunction

   assign step = TICK | TEST;

   always_comb begin
      state_nx   = state;
      timer_nx   = timer;
      pending_nx = pending;
      blink_nx   = blink;
      pack_nx    = 1'b0;
`ifdef TL_DEMAND_EN
      demand_nx  = demand;
`endif
      if (step) begin
         if (state == S_FLASH) begin
            // Leaving flash wins over the blink toggle on the same step.
            if (!FM) begin
               state_nx = S_AR2;
               timer_nx = AR_L;
            end else begin
               blink_nx = ~blink;
            end
         end else if (timer != '0) begin
            timer_nx = timer - 1'b1;
         end else begin
            case (state)
               S_G1: state_nx = S_Y1;
               S_Y1: state_nx = S_AR1;
               S_AR1: begin
                  if (FM) state_nx = S_FLASH;
`ifdef TL_DEMAND_EN
                  else if (!demand) state_nx = S_AR2;
`endif
                  else state_nx = S_G2;
               end
               S_G2: state_nx = S_Y2;
               S_Y2: state_nx = S_AR2;
               S_AR2: begin
                  if (FM) state_nx = S_FLASH;
                  else if (pending) state_nx = S_PW;
                  else state_nx = S_G1;
               end
               default: state_nx = S_G1;
            endcase
            timer_nx = load_of(state_nx);
            if (state_nx == S_FLASH) blink_nx = 1'b1;
         end
      end
      if (state_nx == S_PW && state != S_PW) begin
         pending_nx = 1'b0;
      end else if (PREQ && !pending && state != S_PW) begin
         pending_nx = 1'b1;
         pack_nx    = 1'b1;
      end
`ifdef TL_DEMAND_EN
      if (state_nx == S_G2 && state != S_G2) demand_nx = 1'b0;
      else if (VDET2) demand_nx = 1'b1;
`endif
      lamps_nx = decode(state_nx, blink_nx);
   end

   always_ff @(posedge CK or posedge CLR) begin
      if (CLR) begin
         state   <= S_AR2;
         timer   <= AR_L;
         pending <= 1'b0;
         blink   <= 1'b0;
         PACK    <= 1'b0;
         lamps   <= LAMPS_RESET;
`ifdef TL_DEMAND_EN
         demand  <= 1'b0;
`endif
      end else begin
         state   <= state_nx;
         timer   <= timer_nx;
         pending <= pending_nx;
         blink   <= blink_nx;
         PACK    <= pack_nx;
         lamps   <= lamps_nx;
`ifdef TL_DEMAND_EN
         demand  <= demand_nx;
`endif
      end
   end

   assign PHASE = state;
   assign {GRN1, YLW1, RED1, GRN2, YLW2, RED2, WALK} = lamps;

endmodule

// File: tb/tb_tl_phase_scheduler.sv
// Randomized scoreboard bench for tl_phase_scheduler against a phase/elapsed-step model.
module tb_tl_phase_scheduler;

   logic       CK = 1'b0;
   logic       CLR = 1'b0;
   logic       TICK = 1'b0;
   logic       TEST = 1'b0;
   logic       FM = 1'b0;
   logic       PREQ = 1'b0;
   logic       PACK;
   logic       GRN1, YLW1, RED1, GRN2, YLW2, RED2, WALK;
   logic [2:0] PHASE;

   tl_phase_scheduler dut (
      .CK(CK), .CLR(CLR), .TICK(TICK), .TEST(TEST), .FM(FM), .PREQ(PREQ),
`ifdef TL_DEMAND_EN
      .VDET2(1'b1),
`endif
      .PACK(PACK), .GRN1(GRN1), .YLW1(YLW1), .RED1(RED1),
      .GRN2(GRN2), .YLW2(YLW2), .RED2(RED2), .WALK(WALK), .PHASE(PHASE)
   );

   always #5 CK = ~CK;

   int checks = 0;
   int passed = 0;
   int cycle_no = 0;

   // Expected entry: {phase[2:0], lamps[6:0], pack}
   logic [10:0] exp_q[$];

   // Reference model: current phase, steps already spent in it, pending flag, blink.
   int m_ph = 5;
   int m_el = 0;
   bit m_pend = 0;
   bit m_blink = 0;
   bit prev_clr = 0;

   function automatic int dur(input int p);
      case (p)
         0: dur = 10;
         1: dur = 3;
         2: dur = 1;
         3: dur = 6;
         4: dur = 3;
         5: dur = 1;
         6: dur = 4;
         default: dur = 1;
      endcase
   endfunction

   function automatic logic [6:0] lamp_of(input int p, input bit b);
      case (p)
         0: lamp_of = 7'b1000010;
         1: lamp_of = 7'b0100010;
         3: lamp_of = 7'b0011000;
         4: lamp_of = 7'b0010100;
         6: lamp_of = 7'b0010011;
         7: lamp_of = {1'b0, b, 3'b000, b, 1'b0};
         default: lamp_of = 7'b0010010;
      endcase
   endfunction

   task automatic check(input string name, input int got, input int want);
      checks++;
      if (got == want) passed++;
      else $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cycle_no, got, want);
   endtask

   task automatic model_update(input bit clr, input bit tick, input bit test,
                               input bit fm, input bit preq, output bit pack);
      int  nph;
      bit  pk;
      pack = 0;
      if (clr) begin
         m_ph = 5; m_el = 0; m_pend = 0; m_blink = 0;
         return;
      end
      pk  = preq && !m_pend && (m_ph != 6);
      nph = m_ph;
      if (tick || test) begin
         if (m_ph == 7) begin
            if (!fm) begin nph = 5; m_el = 0; end
            else m_blink = !m_blink;
         end else begin
            m_el++;
            if (m_el == dur(m_ph)) begin
               m_el = 0;
               case (m_ph)
                  2: nph = fm ? 7 : 3;
                  5: nph = fm ? 7 : (m_pend ? 6 : 0);
                  6: nph = 0;
                  default: nph = m_ph + 1;
               endcase
               if (nph == 7) m_blink = 1;
            end
         end
      end
      if (nph == 6 && m_ph != 6) m_pend = 0;
      else if (pk) begin m_pend = 1; pack = 1; end
      m_ph = nph;
   endtask

   task automatic cyc(input bit clr, input bit tick, input bit test,
                      input bit fm, input bit preq);
      bit pk;
      @(negedge CK);
      CLR = clr; TICK = tick; TEST = test; FM = fm; PREQ = preq;
      model_update(clr, tick, test, fm, preq, pk);
      exp_q.push_back({3'(m_ph), lamp_of(m_ph, m_blink), pk});
      if (clr && !prev_clr) begin
         #1;
         check("async_clr_phase", int'(PHASE), 5);
         check("async_clr_lamps", int'({GRN1, YLW1, RED1, GRN2, YLW2, RED2, WALK}), 7'b0010010);
      end
      prev_clr = clr;
   endtask

   // Monitor: the DUT presents a registered output set every clock.
   initial begin
      logic [10:0] e;
      forever begin
         @(posedge CK);
         #1;
         cycle_no++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("phase", int'(PHASE), int'(e[10:8]));
            check("lamps", int'({GRN1, YLW1, RED1, GRN2, YLW2, RED2, WALK}), int'(e[7:1]));
            check("pack", int'(PACK), int'(e[0]));
         end
      end
   end

   initial begin
      bit fm_l, preq_l, clr_r;
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      // Free-running test mode: plain G1..AR2 cycling.
      for (int i = 0; i < 80; i++) cyc(0, 0, 1, 0, 0);
      // Sparse timebase.
      for (int i = 0; i < 120; i++) cyc(0, (i % 4) == 3, 0, 0, 0);
      // Pedestrian requests, with occasional long holds.
      preq_l = 0;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 14) == 0) preq_l = !preq_l;
         cyc(0, 0, 1, 0, preq_l);
      end
      // Everything random: flash requests, ticks, resets.
      fm_l = 0; preq_l = 0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 39) == 0) fm_l = !fm_l;
         if ($urandom_range(0, 14) == 0) preq_l = !preq_l;
         clr_r = ($urandom_range(0, 299) == 0);
         cyc(clr_r, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, fm_l, preq_l);
      end
      cyc(0, 0, 1, 0, 0);
      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge CK);
      if (exp_q.size() > 0) begin
         checks++;
         $display("FAIL drain remaining=%0d expected=0", exp_q.size());
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
